// File: rtl/magnitude_comparator_if.sv
// Operand/result bundle for magnitude_comparator; master drives operands, slave returns results.
// signed_mode exists only when MAGNITUDE_COMPARATOR_SIGNED_EN is defined.
interface magnitude_comparator_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             casc_gt;
    logic             casc_lt;
    logic             casc_eq;
`ifdef MAGNITUDE_COMPARATOR_SIGNED_EN
    logic             signed_mode;
`endif
    logic             a_gt_b;
    logic             a_lt_b;
    logic             a_eq_b;
    logic             out_valid;

    modport master (
`ifdef MAGNITUDE_COMPARATOR_SIGNED_EN
        output signed_mode,
`endif
        output in_valid, a, b, casc_gt, casc_lt, casc_eq,
        input  a_gt_b, a_lt_b, a_eq_b, out_valid
    );

    modport slave (
`ifdef MAGNITUDE_COMPARATOR_SIGNED_EN
        input  signed_mode,
`endif
        input  in_valid, a, b, casc_gt, casc_lt, casc_eq,
        output a_gt_b, a_lt_b, a_eq_b, out_valid
    );
endinterface

// File: rtl/magnitude_comparator.sv
// Registered N-bit magnitude comparator with 7485-style cascade inputs, one-cycle latency.
// Define MAGNITUDE_COMPARATOR_SIGNED_EN to add a two's-complement signed_mode input.
module magnitude_comparator #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    magnitude_comparator_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             signedMode;

    logic gt_d, lt_d, eq_d;
    logic gt_q, lt_q, eq_q;
    logic valid_q;
    logic decided;

    assign opA = bus.a;
    assign opB = bus.b;
`ifdef MAGNITUDE_COMPARATOR_SIGNED_EN
    assign signedMode = bus.signed_mode;
`else
    assign signedMode = 1'b0;
`endif

    // First differing bit from the MSB decides; cascade inputs only matter on a full tie.
    always_comb begin
        gt_d    = 1'b0;
        lt_d    = 1'b0;
        eq_d    = 1'b0;
        decided = 1'b0;
        for (int i = MSB; i >= 0; i--) begin
            if (!decided && (opA[i] != opB[i])) begin
                decided = 1'b1;
                gt_d    = opA[i];
                lt_d    = opB[i];
            end
        end
        if (signedMode && (opA[MSB] != opB[MSB])) begin
            gt_d = opB[MSB];
            lt_d = opA[MSB];
        end
        if (!decided) begin
            if (bus.casc_eq) begin
                eq_d = 1'b1;
            end else if (bus.casc_gt && !bus.casc_lt) begin
                gt_d = 1'b1;
            end else if (bus.casc_lt && !bus.casc_gt) begin
                lt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                gt_q <= gt_d;
                lt_q <= lt_d;
                eq_q <= eq_d;
            end
        end
    end

    assign bus.a_gt_b    = gt_q;
    assign bus.a_lt_b    = lt_q;
    assign bus.a_eq_b    = eq_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_magnitude_comparator.sv
// Directed self-checking bench for magnitude_comparator (WIDTH=4).
// Signed-mode vectors run only when MAGNITUDE_COMPARATOR_SIGNED_EN is defined.
module tb_magnitude_comparator;
    logic clk;
    logic rst;
    int   checkCount;
    int   passCount;

    magnitude_comparator_if #(.WIDTH(4)) bus ();

    magnitude_comparator #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Applies one input set, clocks once, and compares {gt,lt,eq,out_valid} 1 time unit after the edge.
    task automatic step(input logic valid, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] casc, input logic sgn, input logic [3:0] expected,
                        input string name);
        logic [3:0] got;
        bus.in_valid = valid;
        bus.a        = a;
        bus.b        = b;
        bus.casc_gt  = casc[2];
        bus.casc_lt  = casc[1];
        bus.casc_eq  = casc[0];
`ifdef MAGNITUDE_COMPARATOR_SIGNED_EN
        bus.signed_mode = sgn;
`endif
        @(posedge clk);
        #1;
        got = {bus.a_gt_b, bus.a_lt_b, bus.a_eq_b, bus.out_valid};
        checkCount++;
        if (got !== expected)
            $display("[TB] FAIL %s: gt/lt/eq/valid got %b required %b", name, got, expected);
        else
            passCount++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 4'h0, 4'h0, 3'b001, 1'b0, 4'b0010, "reset_cycle1");
        step(1'b0, 4'h0, 4'h0, 3'b001, 1'b0, 4'b0010, "reset_cycle2");
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] va [6] = '{4'b1001, 4'b1111, 4'b0000, 4'b0101, 4'b1111, 4'b0000};
        logic [3:0] vb [6] = '{4'b1000, 4'b1100, 4'b1000, 4'b1011, 4'b1111, 4'b0000};
        logic [3:0] ve [6] = '{4'b1001, 4'b1001, 4'b0101, 4'b0101, 4'b0011, 4'b0011};
        for (int i = 0; i < 6; i++)
            step(1'b1, va[i], vb[i], 3'b001, 1'b0, ve[i], $sformatf("unsigned_%0d", i));
    endtask

    task automatic test_hold();
        step(1'b1, 4'b0101, 4'b1011, 3'b001, 1'b0, 4'b0101, "hold_setup_lt");
        step(1'b0, 4'b0011, 4'b0001, 3'b001, 1'b0, 4'b0100, "hold_cycle1");
        step(1'b0, 4'b0011, 4'b0001, 3'b001, 1'b0, 4'b0100, "hold_cycle2");
    endtask

    task automatic test_cascade();
        step(1'b1, 4'b0110, 4'b0110, 3'b100, 1'b0, 4'b1001, "casc_gt");
        step(1'b1, 4'b0110, 4'b0110, 3'b010, 1'b0, 4'b0101, "casc_lt");
        step(1'b1, 4'b0110, 4'b0110, 3'b000, 1'b0, 4'b0001, "casc_none");
        step(1'b1, 4'b0110, 4'b0110, 3'b110, 1'b0, 4'b0001, "casc_gt_lt");
        step(1'b1, 4'b0110, 4'b0110, 3'b111, 1'b0, 4'b0011, "casc_eq_wins");
        step(1'b1, 4'b0111, 4'b0110, 3'b010, 1'b0, 4'b1001, "casc_operand_dominates");
        step(1'b1, 4'b0010, 4'b0011, 3'b100, 1'b0, 4'b0101, "casc_ignored_lsb_lt");
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 4'b0001, 4'b1000, 3'b001, 1'b0, 4'b0101, "mid_setup_lt");
        rst = 1'b1;
        step(1'b1, 4'b1000, 4'b0001, 3'b001, 1'b0, 4'b0010, "mid_reset_discard");
        rst = 1'b0;
        step(1'b1, 4'b1000, 4'b0001, 3'b001, 1'b0, 4'b1001, "mid_after_reset_gt");
        step(1'b0, 4'b1000, 4'b0001, 3'b001, 1'b0, 4'b1000, "mid_valid_drops");
    endtask

`ifdef MAGNITUDE_COMPARATOR_SIGNED_EN
    task automatic test_signed();
        step(1'b1, 4'b1000, 4'b0111, 3'b001, 1'b1, 4'b0101, "signed_neg_vs_pos");
        step(1'b1, 4'b1000, 4'b0111, 3'b001, 1'b0, 4'b1001, "unsigned_same_ops");
        step(1'b1, 4'b1110, 4'b1010, 3'b001, 1'b1, 4'b1001, "signed_both_neg");
        step(1'b1, 4'b0001, 4'b1111, 3'b001, 1'b1, 4'b1001, "signed_pos_vs_neg");
    endtask
`endif

    initial begin
        checkCount   = 0;
        passCount    = 0;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.casc_gt  = 1'b0;
        bus.casc_lt  = 1'b0;
        bus.casc_eq  = 1'b1;
`ifdef MAGNITUDE_COMPARATOR_SIGNED_EN
        bus.signed_mode = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_hold();
        test_cascade();
        test_reset_midstream();
`ifdef MAGNITUDE_COMPARATOR_SIGNED_EN
        test_signed();
`endif
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
